// File: rtl/traffic_light.sv
// traffic_light: highway / country-road crossing controller.
// The highway holds green by default. The country road is served only when a
// car is sensed and the highway minimum green has run out.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   sensor           1 = car waiting on the country road (synchronous to clk)
//   HW_LED, CR_LED   lamps {red, yellow, green}, one-hot, active-high
//   hw_time_display  HW countdown, [13:7] tens digit, [6:0] ones digit,
//                    active-low segments {g,f,e,d,c,b,a}
//   cr_time_display  CR countdown, same format
module traffic_light #(
  parameter int TICK_DIV = 1,
  parameter int HW_GREEN = 30,
  parameter int CR_GREEN = 20,
  parameter int YELLOW   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sensor,
  output logic [2:0]  HW_LED,
  output logic [2:0]  CR_LED,
  output logic [13:0] hw_time_display,
  output logic [13:0] cr_time_display
);

  localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [6:0]     T_HWG   = 7'(HW_GREEN);
  localparam logic [6:0]     T_CRG   = 7'(CR_GREEN);
  localparam logic [6:0]     T_YEL   = 7'(YELLOW);
  localparam logic [2:0]     L_GRN   = 3'b001;
  localparam logic [2:0]     L_YEL   = 3'b010;
  localparam logic [2:0]     L_RED   = 3'b100;

  typedef enum logic [1:0] {HW_G, HW_Y, CR_G, CR_Y} state_t;

  state_t        state;
  logic [6:0]    count;
  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  // Lamps are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HW_G;
      count  <= T_HWG;
      HW_LED <= L_GRN;
      CR_LED <= L_RED;
    end else if (tick) begin
      unique case (state)
        HW_G: begin
          // count 0 means minimum green already served; wait for a car
          if ((count <= 7'd1) && sensor) begin
            state  <= HW_Y;
            count  <= T_YEL;
            HW_LED <= L_YEL;
          end else if (count == 7'd1) count <= 7'd0;
          else if (count != 7'd0)     count <= count - 7'd1;
        end
        HW_Y: begin
          if (count == 7'd1) begin
            state  <= CR_G;
            count  <= T_CRG;
            HW_LED <= L_RED;
            CR_LED <= L_GRN;
          end else count <= count - 7'd1;
        end
        CR_G: begin
          // road emptied: cut the country-road green short
          if (!sensor || (count == 7'd1)) begin
            state  <= CR_Y;
            count  <= T_YEL;
            CR_LED <= L_YEL;
          end else count <= count - 7'd1;
        end
        CR_Y: begin
          if (count == 7'd1) begin
            state  <= HW_G;
            count  <= T_HWG;
            HW_LED <= L_GRN;
            CR_LED <= L_RED;
          end else count <= count - 7'd1;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] two_digit(input logic [6:0] v);
    two_digit = {seg7(4'(v / 7'd10)), seg7(4'(v % 7'd10))};
  endfunction

  // The red road counts down to its own green, so it adds the other road's
  // yellow while that road is still green.
  logic [6:0] hw_val, cr_val;
  always_comb begin
    hw_val = count;
    cr_val = count;
    if (state == HW_G) cr_val = count + T_YEL;
    if (state == CR_G) hw_val = count + T_YEL;
  end

  assign hw_time_display = two_digit(hw_val);
  assign cr_time_display = two_digit(cr_val);

endmodule

// File: tb/tb_traffic_light.sv
module tb_traffic_light;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sensor = 1'b0;
  logic [2:0]  hl [2];
  logic [2:0]  cl [2];
  logic [13:0] hd [2];
  logic [13:0] cd [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  traffic_light #(.TICK_DIV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .sensor(sensor),
    .HW_LED(hl[0]), .CR_LED(cl[0]),
    .hw_time_display(hd[0]), .cr_time_display(cd[0])
  );

  traffic_light #(.TICK_DIV(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .sensor(sensor),
    .HW_LED(hl[1]), .CR_LED(cl[1]),
    .hw_time_display(hd[1]), .cr_time_display(cd[1])
  );

  // ---------------- behavioural model ----------------
  // phase 0..3 = HW green, HW yellow, CR green, CR yellow; rem = ticks left
  int ph  [2] = '{0, 0};
  int rem [2] = '{30, 30};
  int pre [2] = '{0, 0};
  int tdiv [2] = '{1, 4};

  logic [6:0] segt [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000};

  function automatic int dur(input int p);
    case (p)
      0:       return 30;
      2:       return 20;
      default: return 3;
    endcase
  endfunction

  function automatic logic [13:0] disp(input int n);
    return {segt[n / 10], segt[n % 10]};
  endfunction

  task automatic advance(input int d);
    ph[d]  = (ph[d] + 1) % 4;
    rem[d] = dur(ph[d]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        ph[d] = 0; rem[d] = 30; pre[d] = 0;
      end else begin
        bit tk;
        tk = (pre[d] == tdiv[d] - 1);
        pre[d] = tk ? 0 : pre[d] + 1;
        if (tk) begin
          if (ph[d] == 2 && !sensor) advance(d);
          else if (rem[d] > 0) begin
            rem[d]--;
            if (rem[d] == 0 && (ph[d] != 0 || sensor)) advance(d);
          end else if (sensor) advance(d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [2:0] eh, ec;
      int hn, cn;
      eh = (ph[d] == 0) ? 3'b001 : (ph[d] == 1) ? 3'b010 : 3'b100;
      ec = (ph[d] == 2) ? 3'b001 : (ph[d] == 3) ? 3'b010 : 3'b100;
      hn = (ph[d] == 2) ? rem[d] + 3 : rem[d];
      cn = (ph[d] == 0) ? rem[d] + 3 : rem[d];
      chk($sformatf("hw_led[%0d]", d),  14'(hl[d]), 14'(eh));
      chk($sformatf("cr_led[%0d]", d),  14'(cl[d]), 14'(ec));
      chk($sformatf("hw_disp[%0d]", d), hd[d], disp(hn));
      chk($sformatf("cr_disp[%0d]", d), cd[d], disp(cn));
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [13:0] D30 = {7'b0110000, 7'b1000000};
  localparam logic [13:0] D33 = {7'b0110000, 7'b0110000};
  localparam logic [13:0] D00 = {7'b1000000, 7'b1000000};
  localparam logic [13:0] D03 = {7'b1000000, 7'b0110000};
  localparam logic [13:0] D12 = {7'b1111001, 7'b0100100};
  localparam logic [13:0] D15 = {7'b1111001, 7'b0010010};

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // long reset with sensor low
    cyc(250);
    chk("rst_hw_led", 14'(hl[0]), 14'(3'b001));
    chk("rst_cr_led", 14'(cl[0]), 14'(3'b100));
    chk("rst_hw_disp", hd[0], D30);
    chk("rst_cr_disp", cd[0], D33);
    chk("rst_model_rem", 14'(rem[0]), 14'd30);

    // sensor low: HW counts to 1 then holds 00, CR shows 03
    rst_n = 1'b1;
    cyc(40);
    chk("hold_hw_disp", hd[0], D00);
    chk("hold_cr_disp", cd[0], D03);
    chk("hold_cr_led", 14'(cl[0]), 14'(3'b100));

    // car arrives while holding: yellow on the very next edge
    sensor = 1'b1;
    cyc(1);
    chk("late_hw_yel", 14'(hl[0]), 14'(3'b010));
    chk("late_cr_disp", cd[0], D03);
    cyc(130);

    // fresh start, sensor held; drop it at CR_G count 12
    rst_n = 1'b0;
    #1;
    chk("midrst_hw_led", 14'(hl[0]), 14'(3'b001));
    chk("midrst_hw_disp", hd[0], D30);
    cyc(3);
    rst_n = 1'b1;
    sensor = 1'b1;
    cyc(41);
    chk("crg12_cr_disp", cd[0], D12);
    chk("crg12_hw_disp", hd[0], D15);
    sensor = 1'b0;
    cyc(1);
    chk("early_cr_yel", 14'(cl[0]), 14'(3'b010));
    chk("early_cr_disp", cd[0], D03);
    cyc(3);
    chk("resume_hw_led", 14'(hl[0]), 14'(3'b001));
    chk("resume_hw_disp", hd[0], D30);

    // sensor held for several full periods (both prescaler settings)
    sensor = 1'b1;
    cyc(500);

    // short sensor pulses, some landing between DIV=4 ticks
    for (int i = 0; i < 300; i++) begin
      sensor = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    sensor = 1'b0;
    cyc(150);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
